vector_operand_stage: RTL and testbench

- Operand-collection stage directly upstream of vector_logic_unit.
- Accepts one issued vector instruction per handshake and reads vs2/vs1 from the vector register file (VRF) through a synchronous read port.
- Forms the second operand from VRF data (.vv), a splatted scalar (.vx) or a splatted immediate (.vi).
- Presents execution_vector, vs2 and vs1 as a registered, valid/ready-handshaked bundle to the logic unit.

---
 rtl/vector_operand_stage.sv | 155 +++++++++++++++
 tb/tb_vector_operand_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_operand_stage.sv
// Vector operand collection stage: VRF read, vx/vi splat, and a
// registered valid/ready bundle toward the vector logic unit.
package vector_operand_pkg;
  typedef struct packed {
    logic [5:0] funct6;
    logic [4:0] vd;
    logic       vm;
  } execution_vector_t;
endpackage

module vector_operand_stage
  import vector_operand_pkg::*;
#(
  parameter int VLEN    = 64,
  parameter int ELEN    = 64,
  parameter int VREG_AW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  execution_vector_t      issue_ev_i,
  input  logic [VREG_AW-1:0]     issue_vs2_addr_i,
  input  logic [VREG_AW-1:0]     issue_vs1_addr_i,
  input  logic [1:0]             issue_opsel_i,
  input  logic [1:0]             issue_sew_i,
  input  logic [ELEN-1:0]        issue_rs1_i,
  input  logic [4:0]             issue_imm_i,
  output logic                   vrf_rd_en_o,
  output logic [VREG_AW-1:0]     vrf_rd_addr_a_o,
  output logic [VREG_AW-1:0]     vrf_rd_addr_b_o,
  input  logic [VLEN-1:0]        vrf_rd_data_a_i,
  input  logic [VLEN-1:0]        vrf_rd_data_b_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output execution_vector_t      execution_vector,
  output logic [VLEN-1:0]        vs2,
  output logic [VLEN-1:0]        vs1,
  output logic                   illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD
  } state_t;

  state_t            r_state;
  execution_vector_t r_ev;
  logic [1:0]        r_opsel;
  logic [1:0]        r_sew;
  logic [63:0]       r_rs1;
  logic [4:0]        r_imm;
  logic              r_valid;
  logic              r_illegal;
  logic [VLEN-1:0]   r_vs2;
  logic [VLEN-1:0]   r_vs1;
  execution_vector_t r_ev_out;

  logic              w_ready;
  logic              w_acc;
  logic              w_bad;
  logic              w_legal;
  logic [63:0]       w_imm64;
  logic [VLEN-1:0]   w_vs1;

  function automatic logic [VLEN-1:0] splat(
    input logic [63:0] v,
    input logic [1:0]  sew
  );
    logic [VLEN-1:0] s;
    s = '0;
    unique case (1'b1)
      (sew == 2'b00): s = {(VLEN/8){v[7:0]}};
      (sew == 2'b01): s = {(VLEN/16){v[15:0]}};
      (sew == 2'b10): s = {(VLEN/32){v[31:0]}};
      default:        s = {(VLEN/64){v}};
    endcase
    return s;
  endfunction

  assign w_ready = (r_state == S_IDLE) |
                   ((r_state == S_HOLD) & out_ready_i);
  assign w_acc   = issue_valid_i & w_ready;
  assign w_bad   = w_acc & (issue_opsel_i == 2'b11);
  assign w_legal = w_acc & ~w_bad;

  assign issue_ready_o   = w_ready;
  assign vrf_rd_en_o     = w_legal;
  assign vrf_rd_addr_a_o = issue_vs2_addr_i;
  assign vrf_rd_addr_b_o = issue_vs1_addr_i;

  // Low SEW bits of the sign-extended simm5 equal simm5 extended to SEW.
  assign w_imm64 = {{59{r_imm[4]}}, r_imm};

  always_comb begin
    w_vs1 = '0;
    unique case (1'b1)
      (r_opsel == 2'b00): w_vs1 = vrf_rd_data_b_i;
      (r_opsel == 2'b01): w_vs1 = splat(r_rs1, r_sew);
      default:            w_vs1 = splat(w_imm64, r_sew);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ev      <= '0;
      r_opsel   <= '0;
      r_sew     <= '0;
      r_rs1     <= '0;
      r_imm     <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_vs2     <= '0;
      r_vs1     <= '0;
      r_ev_out  <= '0;
    end else begin
      r_illegal <= w_bad;
      if (w_legal) begin
        r_ev    <= issue_ev_i;
        r_opsel <= issue_opsel_i;
        r_sew   <= issue_sew_i;
        r_rs1   <= 64'(issue_rs1_i);
        r_imm   <= issue_imm_i;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_legal) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_vs2    <= vrf_rd_data_a_i;
          r_vs1    <= w_vs1;
          r_ev_out <= r_ev;
          r_valid  <= 1'b1;
          r_state  <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready_i) begin
            r_valid <= 1'b0;
            r_state <= w_legal ? S_FETCH : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid_o      = r_valid;
  assign illegal_o        = r_illegal;
  assign vs2              = r_vs2;
  assign vs1              = r_vs1;
  assign execution_vector = r_ev_out;

endmodule

// File: tb/tb_vector_operand_stage.sv
// Scoreboard bench for vector_operand_stage: directed vv/vx/vi,
// backpressure, illegal opsel and asynchronous reset.
module tb_vector_operand_stage;
  import vector_operand_pkg::*;

  localparam int VLEN = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_valid_i;
  logic              issue_ready_o;
  execution_vector_t issue_ev_i;
  logic [4:0]        issue_vs2_addr_i;
  logic [4:0]        issue_vs1_addr_i;
  logic [1:0]        issue_opsel_i;
  logic [1:0]        issue_sew_i;
  logic [63:0]       issue_rs1_i;
  logic [4:0]        issue_imm_i;
  logic              vrf_rd_en_o;
  logic [4:0]        vrf_rd_addr_a_o;
  logic [4:0]        vrf_rd_addr_b_o;
  logic [VLEN-1:0]   vrf_rd_data_a_i;
  logic [VLEN-1:0]   vrf_rd_data_b_i;
  logic              out_valid_o;
  logic              out_ready_i;
  execution_vector_t execution_vector;
  logic [VLEN-1:0]   vs2;
  logic [VLEN-1:0]   vs1;
  logic              illegal_o;

  vector_operand_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_ev_i       (issue_ev_i),
    .issue_vs2_addr_i (issue_vs2_addr_i),
    .issue_vs1_addr_i (issue_vs1_addr_i),
    .issue_opsel_i    (issue_opsel_i),
    .issue_sew_i      (issue_sew_i),
    .issue_rs1_i      (issue_rs1_i),
    .issue_imm_i      (issue_imm_i),
    .vrf_rd_en_o      (vrf_rd_en_o),
    .vrf_rd_addr_a_o  (vrf_rd_addr_a_o),
    .vrf_rd_addr_b_o  (vrf_rd_addr_b_o),
    .vrf_rd_data_a_i  (vrf_rd_data_a_i),
    .vrf_rd_data_b_i  (vrf_rd_data_b_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .execution_vector (execution_vector),
    .vs2              (vs2),
    .vs1              (vs1),
    .illegal_o        (illegal_o)
  );

  always #5 clk = ~clk;

  logic [63:0] vrf [32];

  always @(posedge clk) begin
    if (vrf_rd_en_o) begin
      vrf_rd_data_a_i <= vrf[vrf_rd_addr_a_o];
      vrf_rd_data_b_i <= vrf[vrf_rd_addr_b_o];
    end
  end

  typedef struct {
    logic [63:0]       vs2;
    logic [63:0]       vs1;
    execution_vector_t ev;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        m_e = sb.pop_front();
        check("sb_vs2", vs2, m_e.vs2);
        check("sb_vs1", vs1, m_e.vs1);
        check("sb_ev", 64'(execution_vector), 64'(m_e.ev));
      end
    end
  end

  task automatic drive(input execution_vector_t ev, input logic [4:0] a2,
                       input logic [4:0] a1, input logic [1:0] op,
                       input logic [1:0] sew, input logic [63:0] rs1,
                       input logic [4:0] imm);
    issue_ev_i       = ev;
    issue_vs2_addr_i = a2;
    issue_vs1_addr_i = a1;
    issue_opsel_i    = op;
    issue_sew_i      = sew;
    issue_rs1_i      = rs1;
    issue_imm_i      = imm;
    issue_valid_i    = 1'b1;
  endtask

  task automatic scramble();
    issue_valid_i = 1'b0;
    issue_opsel_i = 2'b11;
    issue_sew_i   = ~issue_sew_i;
    issue_rs1_i   = ~issue_rs1_i;
    issue_imm_i   = ~issue_imm_i;
  endtask

  task automatic wait_valid(input string nm, output int n);
    n = 1;
    while (!out_valid_o && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid_o) check({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_op(input string nm, input execution_vector_t ev,
                       input logic [4:0] a2, input logic [4:0] a1,
                       input logic [1:0] op, input logic [1:0] sew,
                       input logic [63:0] rs1, input logic [4:0] imm,
                       input logic [63:0] exp_vs1,
                       output logic [63:0] o_and);
    int n;
    @(posedge clk); #1;
    drive(ev, a2, a1, op, sew, rs1, imm);
    @(negedge clk);
    check({nm, "_rd_en"}, 64'(vrf_rd_en_o), 64'd1);
    check({nm, "_addr_a"}, 64'(vrf_rd_addr_a_o), 64'(a2));
    sb.push_back('{vs2: vrf[a2], vs1: exp_vs1, ev: ev});
    @(posedge clk); #1;
    scramble();
    wait_valid(nm, n);
    check({nm, "_latency"}, 64'(n), 64'd2);
    o_and = vs2 & vs1;
    @(posedge clk); #1;
  endtask

  execution_vector_t ev_a, ev_b, ev_c;
  logic [63:0]       land;
  int                n;

  initial begin
    for (int i = 0; i < 32; i++) vrf[i] = 64'(i) * 64'h0101_0101_0101_0101;
    vrf[1] = 64'hFFFF0000_AAAA5555;
    vrf[2] = 64'hDEADBEEF_0F0F0F0F;
    vrf[3] = 64'h01234567_89ABCDEF;
    vrf[4] = 64'hFEDCBA98_76543210;
    ev_a = '{funct6: 6'b001001, vd: 5'd3, vm: 1'b1};
    ev_b = '{funct6: 6'b001010, vd: 5'd7, vm: 1'b0};
    ev_c = '{funct6: 6'b001011, vd: 5'd9, vm: 1'b1};
    vrf_rd_data_a_i = '0;
    vrf_rd_data_b_i = '0;
    rst_n       = 1'b0;
    out_ready_i = 1'b0;
    drive(ev_a, 5'd0, 5'd0, 2'b00, 2'b00, 64'd0, 5'd0);
    issue_valid_i = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    check("rst_rd_en", 64'(vrf_rd_en_o), 64'd0);
    check("rst_illegal", 64'(illegal_o), 64'd0);
    check("rst_vs1", vs1, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;

    do_op("vv", ev_a, 5'd2, 5'd1, 2'b00, 2'b00, 64'd0, 5'd0,
          64'hFFFF0000_AAAA5555, land);
    check("vv_vand", land, 64'hDEAD0000_0A0A0505);
    do_op("vx_e8", ev_b, 5'd3, 5'd0, 2'b01, 2'b00,
          64'h12345678_9ABCDEF0, 5'd0, 64'hF0F0F0F0_F0F0F0F0, land);
    do_op("vx_e32", ev_c, 5'd4, 5'd0, 2'b01, 2'b10,
          64'h12345678_9ABCDEF0, 5'd0, 64'h9ABCDEF0_9ABCDEF0, land);
    do_op("vi_e16", ev_a, 5'd2, 5'd0, 2'b10, 2'b01,
          64'hFFFF_FFFF_FFFF_FFFF, 5'b10110, 64'hFFF6FFF6_FFF6FFF6, land);
    do_op("vi_e64", ev_b, 5'd1, 5'd0, 2'b10, 2'b11,
          64'd0, 5'b00111, 64'h00000000_00000007, land);

    // Backpressure with a second issue waiting.
    out_ready_i = 1'b0;
    @(posedge clk); #1;
    drive(ev_a, 5'd3, 5'd4, 2'b00, 2'b00, 64'd0, 5'd0);
    sb.push_back('{vs2: vrf[3], vs1: vrf[4], ev: ev_a});
    @(posedge clk); #1;
    scramble();
    wait_valid("bp_a", n);
    drive(ev_b, 5'd5, 5'd0, 2'b01, 2'b01,
          64'h12345678_9ABCDEF0, 5'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready_low", 64'(issue_ready_o), 64'd0);
      check("bp_no_rd", 64'(vrf_rd_en_o), 64'd0);
      check("bp_vs2_stable", vs2, vrf[3]);
      check("bp_vs1_stable", vs1, vrf[4]);
      @(posedge clk); #1;
    end
    out_ready_i = 1'b1;
    #1;
    check("bp_ready_same_cycle", 64'(issue_ready_o), 64'd1);
    check("bp_rd_same_cycle", 64'(vrf_rd_en_o), 64'd1);
    sb.push_back('{vs2: vrf[5], vs1: 64'hDEF0DEF0_DEF0DEF0, ev: ev_b});
    @(posedge clk); #1;
    scramble();
    check("bp_valid_drop", 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    check("bp_b_valid", 64'(out_valid_o), 64'd1);
    @(posedge clk); #1;

    // Reserved opsel is dropped.
    drive(ev_c, 5'd2, 5'd1, 2'b11, 2'b00, 64'd0, 5'd0);
    @(negedge clk);
    check("ill_no_rd", 64'(vrf_rd_en_o), 64'd0);
    check("ill_ready", 64'(issue_ready_o), 64'd1);
    @(posedge clk); #1;
    scramble();
    check("ill_pulse", 64'(illegal_o), 64'd1);
    check("ill_no_valid", 64'(out_valid_o), 64'd0);
    @(posedge clk); #1;
    check("ill_pulse_end", 64'(illegal_o), 64'd0);
    check("ill_idle", 64'(issue_ready_o), 64'd1);
    @(posedge clk); #1;
    check("ill_no_valid2", 64'(out_valid_o), 64'd0);

    // Asynchronous reset while holding a bundle.
    out_ready_i = 1'b0;
    drive(ev_c, 5'd2, 5'd1, 2'b00, 2'b00, 64'd0, 5'd0);
    sb.push_back('{vs2: vrf[2], vs1: vrf[1], ev: ev_c});
    @(posedge clk); #1;
    scramble();
    wait_valid("rst_hold", n);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid_o), 64'd0);
    check("arst_vs2", vs2, 64'd0);
    check("arst_vs1", vs1, 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check("arst_ready", 64'(issue_ready_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("arst_no_out", 64'(out_valid_o), 64'd0);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
